// File: rtl/dmem_responder.sv
// Single-port data memory responder: one outstanding CPU load/store, a fixed
// number of wait states, then a one-cycle registered ready/rdata/err response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Not covered by reset: contents survive rst_n and start out as zeros.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    logic             fault;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic             mem_we;

    assign fault   = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign idx     = addr_q[IDX_W+1:2];
    assign rd_word = mem_q[idx];
    // The store commits on the edge that leaves RESP, together with the response.
    assign mem_we  = (state_q == S_RESP) && we_q && !fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                err_d   = fault;
                rdata_d = (!fault && !we_q) ? rd_word : 32'h0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 15) driven
// through directed scenarios and random traffic against a word-array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_s   [3];
    logic        we_s    [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [3:0]  be_s    [3];
    logic        ready_s [3];
    logic [31:0] rdata_s [3];
    logic        err_s   [3];
    logic [1:0]  st_s    [3];

    int checks = 0;
    int errors = 0;
    int dbl_ready = 0;
    logic prev_ready [3];
    logic [31:0] model_mem [3][256];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .be(be_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]),
        .err(err_s[0]), .dbg_state(st_s[0]));
    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .be(be_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]),
        .err(err_s[1]), .dbg_state(st_s[1]));
    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst_n(rst_n), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .be(be_s[2]), .ready(ready_s[2]), .rdata(rdata_s[2]),
        .err(err_s[2]), .dbg_state(st_s[2]));

    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 0 : 15;
    endfunction

    function automatic int depth_of(input int s);
        return (s == 0) ? 256 : 16;
    endfunction

    // A response pulse must never be wider than one cycle.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (ready_s[s] === 1'b1 && prev_ready[s] === 1'b1) dbl_ready++;
            prev_ready[s] = ready_s[s];
        end
    end

    // Reference: a word array updated byte by byte; faults leave it untouched.
    task automatic model_apply(input int s, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] b,
                               output logic [31:0] exp_rd, output logic exp_e);
        int word;
        exp_e  = (a % 4 != 0) || ((a / 4) >= 32'(depth_of(s)));
        exp_rd = 32'h0;
        if (!exp_e) begin
            word = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[s][word][8*i +: 8] = wd[8*i +: 8];
            end else begin
                exp_rd = model_mem[s][word];
            end
        end
    endtask

    // Called #1 after a rising edge with the instance idle; returns #1 after
    // the edge that raised ready, with req already dropped. lat = -1 on timeout.
    task automatic do_txn(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          output logic [31:0] rd, output logic e, output int lat);
        req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; wdata_s[s] = wd; be_s[s] = b;
        @(posedge clk); #1;
        lat = 1;
        rd = 32'h0;
        e = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            if (ready_s[s] === 1'b1) begin
                rd = rdata_s[s];
                e = err_s[s];
                break;
            end
            lat++;
            if (lat > 40) begin
                lat = -1;
                break;
            end
        end
        req_s[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ready_s[s] !== 1'b0) begin
                errors++; $display("FAIL reset_ready s=%0d got %b expected 0", s, ready_s[s]);
            end
            checks++;
            if (rdata_s[s] !== 32'h0) begin
                errors++; $display("FAIL reset_rdata s=%0d got %h expected 0", s, rdata_s[s]);
            end
            checks++;
            if (err_s[s] !== 1'b0) begin
                errors++; $display("FAIL reset_err s=%0d got %b expected 0", s, err_s[s]);
            end
            checks++;
            if (st_s[s] !== 2'd0) begin
                errors++; $display("FAIL reset_state s=%0d got %0d expected 0", s, st_s[s]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd, exp_rd;
        logic e, exp_e;
        int lat;
        model_apply(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, exp_rd, exp_e);
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d expected 3", lat); end
        checks++;
        if (e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL store_resp got err=%b rdata=%h expected err=0 rdata=0", e, rd);
        end
        model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, exp_rd, exp_e);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d expected 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL load_data got %h err=%b expected DEADBEEF err=0", rd, e);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, exp_rd;
        logic e, exp_e;
        int lat;
        model_apply(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, exp_rd, exp_e);
        do_txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e, lat);
        model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, exp_rd, exp_e);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_merge got %h expected DEADBEAA", rd); end
        model_apply(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, exp_rd, exp_e);
        do_txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
        checks++;
        if (e !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL be_zero_resp got err=%b lat=%0d expected err=0 lat=3", e, lat);
        end
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_zero_mem got %h expected DEADBEAA", rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd;
        logic e;
        int lat;
        do_txn(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            errors++; $display("FAIL fault_misaligned got err=%b rdata=%h lat=%0d expected 1/0/3", e, rd, lat);
        end
        do_txn(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL fault_range got err=%b rdata=%h expected 1/0", e, rd);
        end
        do_txn(0, 1'b1, 32'h11, 32'h11223344, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL fault_store got err=%b expected 1", e); end
        do_txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL last_word got err=%b rdata=%h expected 0/0", e, rd);
        end
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEAA || e !== 1'b0) begin
            errors++; $display("FAIL fault_no_write got %h err=%b expected DEADBEAA err=0", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp_rd;
        logic e, exp_e, exp_ready;
        int lat, pulses;
        model_apply(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, exp_rd, exp_e);
        do_txn(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL w0_latency got %0d expected 1", lat); end
        pulses = 0;
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h4; be_s[1] = 4'h0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            exp_ready = (c <= 8) && (c % 2 == 0);
            checks++;
            if (ready_s[1] !== exp_ready) begin
                errors++; $display("FAIL b2b_ready cycle=%0d got %b expected %b", c, ready_s[1], exp_ready);
            end
            if (ready_s[1] === 1'b1) begin
                pulses++;
                checks++;
                if (rdata_s[1] !== 32'hCAFEF00D) begin
                    errors++; $display("FAIL b2b_rdata cycle=%0d got %h expected CAFEF00D", c, rdata_s[1]);
                end
            end
            if (c == 8) req_s[1] = 1'b0;
        end
        checks++;
        if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses got %0d expected 4", pulses); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic e;
        int lat, seen;
        // Store aborted in WAIT on the 2-wait instance.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h12345678; be_s[0] = 4'hF;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (st_s[0] !== 2'd1) begin errors++; $display("FAIL abort_wait_state got %0d expected 1", st_s[0]); end
        rst_n = 1'b0;
        #2;
        checks++;
        if (st_s[0] !== 2'd0 || ready_s[0] !== 1'b0) begin
            errors++; $display("FAIL abort_async got state=%0d ready=%b expected 0/0", st_s[0], ready_s[0]);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready_s[0] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_ready got %0d pulses expected 0", seen); end
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL abort_no_write got %h err=%b expected 0 err=0", rd, e);
        end
        // Store aborted in RESP on the 15-wait instance.
        req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 32'h8; wdata_s[2] = 32'hA5A5A5A5; be_s[2] = 4'hF;
        @(posedge clk); #1;
        req_s[2] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (st_s[2] !== 2'd2) begin errors++; $display("FAIL abort_resp_state got %0d expected 2", st_s[2]); end
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready_s[2] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_resp_ready got %0d pulses expected 0", seen); end
        do_txn(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== model_mem[2][2] || lat !== 16) begin
            errors++; $display("FAIL abort_resp_mem got %h lat=%0d expected %h lat=16", rd, lat, model_mem[2][2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, exp_rd;
        logic [3:0] b;
        logic w, e, exp_e;
        int s, dep, idx, pick, lat;
        int last_idx [3] = '{0, 0, 0};
        for (int n = 0; n < 1000; n++) begin
            s    = $urandom_range(0, 2);
            dep  = depth_of(s);
            w    = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 99);
            idx  = (pick < 30) ? last_idx[s] : $urandom_range(0, dep - 1);
            a    = 32'(idx) << 2;
            if (pick >= 95)      a = $urandom;
            else if (pick >= 88) a = a | 32'($urandom_range(1, 3));
            else if (pick >= 80) a = 32'(dep + $urandom_range(0, 5000)) << 2;
            wd = $urandom;
            b  = 4'($urandom_range(0, 15));
            model_apply(s, w, a, wd, b, exp_rd, exp_e);
            do_txn(s, w, a, wd, b, rd, e, lat);
            checks++;
            if (lat !== wait_of(s) + 1) begin
                errors++; $display("FAIL rand_latency n=%0d s=%0d got %0d expected %0d", n, s, lat, wait_of(s) + 1);
            end
            checks++;
            if (e !== exp_e) begin
                errors++; $display("FAIL rand_err n=%0d s=%0d addr=%h got %b expected %b", n, s, a, e, exp_e);
            end
            checks++;
            if (rd !== exp_rd) begin
                errors++; $display("FAIL rand_rdata n=%0d s=%0d addr=%h got %h expected %h", n, s, a, rd, exp_rd);
            end
            last_idx[s] = idx;
        end
    endtask

    task automatic test_ready_pulse();
        checks++;
        if (dbl_ready !== 0) begin
            errors++; $display("FAIL ready_width got %0d double-wide pulses expected 0", dbl_ready);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = '0; wdata_s[s] = '0; be_s[s] = '0;
            prev_ready[s] = 1'b0;
            for (int i = 0; i < 256; i++) model_mem[s][i] = 32'h0;
        end
        test_reset();
        test_store_load();
        test_byte_enable();
        test_fault();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_ready_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 16 to 4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request capture and response; 0 to 15.
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  CPU memory request valid; held with fields stable until ready seen.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data.
REQ-009 be  input  4  store byte enables; be[i] writes wdata[8i+7:8i].
REQ-010 ready  output  1  one-cycle response strobe.
REQ-011 rdata  output  32  load data, valid only while ready=1.
REQ-012 err  output  1  access fault flag, valid only while ready=1.

Function
REQ-013 States: IDLE, WAIT, RESP; single outstanding transaction.
REQ-014 IDLE: req=1 at rising edge captures we, addr, wdata, be into internal registers; go WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 WAIT: wait counter loaded with WAIT_CYCLES-1 on capture, decrements each cycle; go RESP when counter=0.
REQ-016 Latency: req sampled at edge N -> ready=1 during cycle after edge N+WAIT_CYCLES+1 (cycles counted edge to edge), i.e. WAIT_CYCLES+1 clocks.
REQ-017 RESP: ready=1 for exactly one cycle; next state always IDLE; req ignored while in WAIT or RESP.
REQ-018 Back-to-back: requester holding req=1 after ready gets next transaction captured in IDLE cycle following RESP; minimum spacing WAIT_CYCLES+2 cycles per transaction.
REQ-019 Fault: captured addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> err=1 with ready, rdata=0, no memory write.
REQ-020 Load, no fault: rdata = word at index addr[31:2]; be ignored.
REQ-021 Store, no fault: bytes with be[i]=1 written at the RESP edge; other bytes unchanged; rdata=0.
REQ-022 Store with be=4'b0000: ready with err=0, memory unchanged.
REQ-023 Load from an index stored in the previous transaction returns the newly written data (no stale read).
REQ-024 ready, err, rdata driven from registers only; no combinational path from inputs to outputs.
REQ-025 Memory array initialised to all zeros at time zero.

Reset
REQ-026 rst_n=0 forces state IDLE, ready=0, err=0, rdata=0, wait counter=0, captured registers=0, immediately without clock.
REQ-027 Reset in WAIT or RESP aborts the transaction: no memory write, no ready pulse after release.
REQ-028 Memory contents unaffected by reset.
REQ-029 First request accepted at first rising edge with rst_n=1 and req=1.

Verification
REQ-030 Reset release, WAIT_CYCLES=2, store addr=0x10 wdata=0xDEADBEEF be=4'hF, then load 0x10 -> ready exactly 3 cycles after each capture, load rdata=0xDEADBEEF, err=0.
REQ-031 Store addr=0x10 wdata=0x000000AA be=4'b0001 over 0xDEADBEEF, then load -> rdata=0xDEADBEAA.
REQ-032 Load addr=0x12 -> ready with err=1, rdata=0; load addr=DEPTH_WORDS*4 -> err=1; subsequent load 0x10 unchanged.
REQ-033 WAIT_CYCLES=0, req held high for 4 transactions -> ready every 2nd cycle, 4 pulses, each one cycle wide.
REQ-034 rst_n low during WAIT of store to 0x20 with 0x12345678 -> ready stays 0, later load 0x20 returns 0x00000000.
REQ-035 Random loads/stores against a reference word array, 1000 transactions, random WAIT_CYCLES 0..15 -> zero mismatches, ready never high two consecutive cycles.
